// File: rtl/accum_bank.sv
// Multi-lane saturating accumulator bank with a two-stage read-modify-write
// write path, hazard forwarding and a self-timed clear sweep.
module accum_bank #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned NUM_COLS   = 16,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    output logic                           busy,
    input  logic                           wr_en,
    input  logic                           wr_mode,
    input  logic [NUM_COLS-1:0]            wr_mask,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] wr_data,
    input  logic                           rd_en,
    input  logic [AW-1:0]                  rd_addr,
    output logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data,
    output logic                           rd_valid,
    output logic                           sat_flag
);

    localparam int unsigned ROW_W = NUM_COLS * ACC_WIDTH;
    localparam int unsigned IN_W  = NUM_COLS * DATA_WIDTH;
    localparam int unsigned EXT_W = ACC_WIDTH + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [ROW_W-1:0] mem [DEPTH];

    logic [0:0]          state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                sat_q, sat_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ROW_W-1:0]    rd_data_q, rd_data_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_mode_q, s2_mode_d;
    logic [NUM_COLS-1:0] s2_mask_q, s2_mask_d;
    logic [AW-1:0]       s2_addr_q, s2_addr_d;
    logic [IN_W-1:0]     s2_data_q, s2_data_d;
    logic [ROW_W-1:0]    s2_old_q, s2_old_d;

    logic [ROW_W-1:0]    new_row_c;
    logic                sat_hit_c;

    // S2 lane arithmetic: one guard bit above the accumulator detects overflow
    always_comb begin
        logic [DATA_WIDTH-1:0] din_v;
        logic [ACC_WIDTH-1:0]  old_v;
        logic [EXT_W-1:0]      ext_v;
        logic [EXT_W-1:0]      sum_v;
        din_v     = '0;
        old_v     = '0;
        ext_v     = '0;
        sum_v     = '0;
        new_row_c = s2_old_q;
        sat_hit_c = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            din_v = s2_data_q[i*DATA_WIDTH +: DATA_WIDTH];
            old_v = s2_old_q[i*ACC_WIDTH +: ACC_WIDTH];
            ext_v = {{(EXT_W-DATA_WIDTH){din_v[DATA_WIDTH-1]}}, din_v};
            sum_v = {old_v[ACC_WIDTH-1], old_v} + ext_v;
            if (s2_mask_q[i]) begin
                if (s2_mode_q) begin
                    new_row_c[i*ACC_WIDTH +: ACC_WIDTH] = ext_v[ACC_WIDTH-1:0];
                end else if (sum_v[EXT_W-1] != sum_v[EXT_W-2]) begin
                    sat_hit_c = 1'b1;
                    new_row_c[i*ACC_WIDTH +: ACC_WIDTH] = sum_v[EXT_W-1]
                        ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end else begin
                    new_row_c[i*ACC_WIDTH +: ACC_WIDTH] = sum_v[ACC_WIDTH-1:0];
                end
            end
        end
    end

    // Control FSM, S1 accept and read port
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        sat_d      = sat_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        s2_valid_d = 1'b0;
        s2_mode_d  = wr_mode;
        s2_mask_d  = wr_mask;
        s2_addr_d  = wr_addr;
        s2_data_d  = wr_data;
        // Same-row S2 result bypasses the stale memory copy
        s2_old_d   = (s2_valid_q && (s2_addr_q == wr_addr)) ? new_row_c : mem[wr_addr];

        if (s2_valid_q && sat_hit_c) begin
            sat_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    sat_d   = 1'b0;
                end else begin
                    s2_valid_d = wr_en;
                    rd_valid_d = rd_en;
                    if (rd_en) begin
                        rd_data_d = mem[rd_addr];
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            sat_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_mask_q  <= '0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_old_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            sat_q      <= sat_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_mask_q  <= s2_mask_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
            s2_old_q   <= s2_old_d;
        end
    end

    // Storage has no reset; S2 commit and sweep never coincide
    always_ff @(posedge clk) begin
        if (s2_valid_q) begin
            mem[s2_addr_q] <= new_row_c;
        end else if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end
    end

    assign busy     = busy_q;
    assign sat_flag = sat_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: reset sweep, hazard accumulate, mask/mode,
// saturation, read-after-write window and clear collision.
module tb_accum_bank;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        busy;
    logic        wr_en;
    logic        wr_mode;
    logic [3:0]  wr_mask;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [47:0] rd_data;
    logic        rd_valid;
    logic        sat_flag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] rdv;

    accum_bank #(
        .DATA_WIDTH(8),
        .ACC_WIDTH (12),
        .NUM_COLS  (4),
        .DEPTH     (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_mode (wr_mode),
        .wr_mask (wr_mask),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .sat_flag(sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] acc4(input int a0, input int a1, input int a2, input int a3);
        return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
    endfunction

    function automatic logic [31:0] dat4(input int d0, input int d1, input int d2, input int d3);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [47:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en = 1'b0;
        check("rd_valid_on_read", 48'(rd_valid), 48'd1);
        d = rd_data;
    endtask

    task automatic set_wr(input logic en, input logic mode, input logic [3:0] mask,
                          input logic [3:0] addr, input logic [31:0] data);
        wr_en   = en;
        wr_mode = mode;
        wr_mask = mask;
        wr_addr = addr;
        wr_data = data;
    endtask

    initial begin
        rst_n = 1'b1;
        clear = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        set_wr(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        #2 rst_n = 1'b0;
        step();
        step();
        check("reset_busy",     48'(busy),     48'd1);
        check("reset_rd_valid", 48'(rd_valid), 48'd0);
        check("reset_rd_data",  rd_data,       48'd0);
        check("reset_sat",      48'(sat_flag), 48'd0);

        // Reset sweep with rd_en held high
        rst_n = 1'b1;
        rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("sweep_busy_%0d", k), 48'(busy), (k < 16) ? 48'd1 : 48'd0);
            check($sformatf("sweep_rdv_%0d", k), 48'(rd_valid), 48'd0);
        end
        rd_en = 1'b0;
        for (int r = 0; r < 16; r++) begin
            do_read(4'(r), rdv);
            check($sformatf("swept_row_%0d", r), rdv, 48'd0);
        end
        step();
        check("rd_valid_single_pulse", 48'(rd_valid), 48'd0);

        // Back-to-back accumulates to the same row
        set_wr(1'b1, 1'b0, 4'hF, 4'd3, dat4(5, 5, 5, 5));
        repeat (4) step();
        wr_en = 1'b0;
        step();
        do_read(4'd3, rdv);
        check("hazard_accum_row3", rdv, acc4(20, 20, 20, 20));

        // Overwrite then masked accumulate
        set_wr(1'b1, 1'b1, 4'hF, 4'd7, dat4(1, 2, 3, 4));
        step();
        set_wr(1'b1, 1'b0, 4'b0101, 4'd7, dat4(10, 10, 10, 10));
        step();
        wr_en = 1'b0;
        step();
        do_read(4'd7, rdv);
        check("mask_mode_row7", rdv, acc4(11, 2, 13, 4));
        check("sat_clear_before", 48'(sat_flag), 48'd0);

        // Positive saturation on lane 0 of row 0
        set_wr(1'b1, 1'b0, 4'b0001, 4'd0, dat4(127, 0, 0, 0));
        repeat (17) step();
        wr_en = 1'b0;
        check("sat_low_after_16", 48'(sat_flag), 48'd0);
        step();
        check("sat_high_after_17", 48'(sat_flag), 48'd1);
        do_read(4'd0, rdv);
        check("sat_pos_row0", rdv, acc4(2047, 0, 0, 0));

        // Negative saturation on lane 0 of row 1
        set_wr(1'b1, 1'b0, 4'b0001, 4'd1, dat4(-128, 0, 0, 0));
        repeat (17) step();
        wr_en = 1'b0;
        step();
        do_read(4'd1, rdv);
        check("sat_neg_row1", rdv, acc4(-2048, 0, 0, 0));
        check("sat_sticky", 48'(sat_flag), 48'd1);

        // Read-after-write window on row 2
        set_wr(1'b1, 1'b0, 4'hF, 4'd2, dat4(9, 9, 9, 9));
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        step();
        wr_en = 1'b0;
        check("raw_t_valid", 48'(rd_valid), 48'd1);
        check("raw_t_data",  rd_data, 48'd0);
        step();
        check("raw_t1_data", rd_data, 48'd0);
        step();
        rd_en = 1'b0;
        check("raw_t2_data", rd_data, acc4(9, 9, 9, 9));
        step();
        check("raw_valid_drop", 48'(rd_valid), 48'd0);
        check("raw_data_hold",  rd_data, acc4(9, 9, 9, 9));

        // Clear colliding with a write in S2 and new requests
        set_wr(1'b1, 1'b0, 4'hF, 4'd5, dat4(6, 6, 6, 6));
        step();
        set_wr(1'b1, 1'b0, 4'hF, 4'd5, dat4(1, 1, 1, 1));
        clear   = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step();
        clear = 1'b0;
        check("clr_busy_t1",  48'(busy),     48'd1);
        check("clr_no_rdv",   48'(rd_valid), 48'd0);
        check("clr_sat_zero", 48'(sat_flag), 48'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("clr_busy_%0d", k), 48'(busy), (k < 16) ? 48'd1 : 48'd0);
            check($sformatf("clr_rdv_%0d", k), 48'(rd_valid), 48'd0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        do_read(4'd5, rdv);
        check("clr_row5_zero", rdv, 48'd0);
        do_read(4'd0, rdv);
        check("clr_row0_zero", rdv, 48'd0);
        check("clr_sat_stays_zero", 48'(sat_flag), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
